// File: rtl/sp_reg_file_tagged.sv
// Tagged special-purpose register file: each entry holds a value and a rename tag.
// Reads are combinational with result-broadcast bypass; illegal accesses are captured in a sticky record.
module sp_reg_file_tagged #(
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  parameter int RS_ID_WIDTH = 5,
  parameter int NUM_SPR     = 3,
  parameter logic [NUM_SPR-1:0][9:0] SPR_ADDRS = {10'd9, 10'd8, 10'd1}
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [READ_PORTS-1:0][9:0]              read_addr,
  output logic [READ_PORTS-1:0]                   read_value_valid,
  output logic [READ_PORTS-1:0][31:0]             read_value,
  output logic [READ_PORTS-1:0][RS_ID_WIDTH-1:0]  read_rs_id,
  output logic [READ_PORTS-1:0]                   read_illegal,
  input  logic [WRITE_PORTS-1:0]                  write_enable,
  input  logic [WRITE_PORTS-1:0][9:0]             write_addr,
  input  logic [WRITE_PORTS-1:0][RS_ID_WIDTH-1:0] write_rs_id,
  input  logic [WRITE_PORTS-1:0][31:0]            write_value,
  input  logic                                    update_enable,
  input  logic [9:0]                              update_addr,
  input  logic [RS_ID_WIDTH-1:0]                  update_rs_id,
  input  logic                                    flush,
  output logic                                    err_valid,
  output logic [9:0]                              err_addr,
  output logic [1:0]                              err_src,
  input  logic                                    err_clear
);

  localparam logic [1:0] SRC_READ   = 2'd0;
  localparam logic [1:0] SRC_WRITE  = 2'd1;
  localparam logic [1:0] SRC_UPDATE = 2'd2;

  logic [NUM_SPR-1:0]                  valid_q, valid_d;
  logic [NUM_SPR-1:0][31:0]            value_q, value_d;
  logic [NUM_SPR-1:0][RS_ID_WIDTH-1:0] rs_id_q, rs_id_d;
  logic                                err_valid_q, err_valid_d;
  logic [9:0]                          err_addr_q, err_addr_d;
  logic [1:0]                          err_src_q, err_src_d;

  logic [READ_PORTS-1:0][NUM_SPR-1:0]  rd_sel;
  logic [WRITE_PORTS-1:0][NUM_SPR-1:0] wr_sel;
  logic [WRITE_PORTS-1:0][NUM_SPR-1:0] wr_match;
  logic [NUM_SPR-1:0]                  upd_sel;

  logic       new_err;
  logic [9:0] new_err_addr;
  logic [1:0] new_err_src;

  // One-hot decode; on duplicate addresses only the lowest index is selected.
  function automatic logic [NUM_SPR-1:0] decode(input logic [9:0] addr);
    logic [NUM_SPR-1:0] sel;
    sel = '0;
    for (int e = NUM_SPR - 1; e >= 0; e--) begin
      if (addr == SPR_ADDRS[e]) begin
        sel    = '0;
        sel[e] = 1'b1;
      end
    end
    return sel;
  endfunction

  always_comb begin
    rd_sel   = '0;
    wr_sel   = '0;
    wr_match = '0;
    upd_sel  = decode(update_addr);
    for (int r = 0; r < READ_PORTS; r++) begin
      rd_sel[r] = decode(read_addr[r]);
    end
    for (int w = 0; w < WRITE_PORTS; w++) begin
      wr_sel[w] = decode(write_addr[w]);
      for (int e = 0; e < NUM_SPR; e++) begin
        wr_match[w][e] = write_enable[w] && wr_sel[w][e] && !valid_q[e] &&
                         (write_rs_id[w] == rs_id_q[e]);
      end
    end
  end

  // Read ports: stored state, overridden by a matching broadcast when the entry is pending.
  always_comb begin
    read_value_valid = '0;
    read_value       = '0;
    read_rs_id       = '0;
    read_illegal     = '0;
    for (int r = 0; r < READ_PORTS; r++) begin
      read_illegal[r] = ~|rd_sel[r];
      for (int e = 0; e < NUM_SPR; e++) begin
        if (rd_sel[r][e]) begin
          read_value_valid[r] = valid_q[e];
          read_value[r]       = value_q[e];
          read_rs_id[r]       = rs_id_q[e];
          for (int w = WRITE_PORTS - 1; w >= 0; w--) begin
            if (wr_match[w][e]) begin
              read_value_valid[r] = 1'b1;
              read_value[r]       = write_value[w];
            end
          end
        end
      end
    end
  end

  // Entry update: writes commit first, a rename then clears valid but keeps the written value.
  always_comb begin
    valid_d = valid_q;
    value_d = value_q;
    rs_id_d = rs_id_q;
    for (int e = 0; e < NUM_SPR; e++) begin
      for (int w = WRITE_PORTS - 1; w >= 0; w--) begin
        if (wr_match[w][e]) begin
          valid_d[e] = 1'b1;
          value_d[e] = write_value[w];
        end
      end
      if (update_enable && upd_sel[e]) begin
        valid_d[e] = 1'b0;
        rs_id_d[e] = update_rs_id;
      end
    end
    if (flush) begin
      valid_d = '1;
      value_d = value_q;
      rs_id_d = rs_id_q;
    end
  end

  // Later assignments overwrite earlier ones, so the loops run from lowest to highest priority.
  always_comb begin
    new_err      = 1'b0;
    new_err_addr = '0;
    new_err_src  = SRC_READ;
    for (int r = READ_PORTS - 1; r >= 0; r--) begin
      if (~|rd_sel[r]) begin
        new_err      = 1'b1;
        new_err_addr = read_addr[r];
        new_err_src  = SRC_READ;
      end
    end
    for (int w = WRITE_PORTS - 1; w >= 0; w--) begin
      if (write_enable[w] && ~|wr_sel[w]) begin
        new_err      = 1'b1;
        new_err_addr = write_addr[w];
        new_err_src  = SRC_WRITE;
      end
    end
    if (update_enable && ~|upd_sel) begin
      new_err      = 1'b1;
      new_err_addr = update_addr;
      new_err_src  = SRC_UPDATE;
    end

    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    err_src_d   = err_src_q;
    if (err_clear) begin
      err_valid_d = 1'b0;
    end
    if (new_err && (err_clear || !err_valid_q)) begin
      err_valid_d = 1'b1;
      err_addr_d  = new_err_addr;
      err_src_d   = new_err_src;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= '1;
      value_q     <= '0;
      rs_id_q     <= '0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_src_q   <= SRC_READ;
    end else begin
      valid_q     <= valid_d;
      value_q     <= value_d;
      rs_id_q     <= rs_id_d;
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
      err_src_q   <= err_src_d;
    end
  end

  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;
  assign err_src   = err_src_q;

endmodule

// File: doc/sp_reg_file_tagged.md
SP_REG_FILE_TAGGED -- requirements
Module: sp_reg_file_tagged

Interface
REQ-001 SHALL provide parameter READ_PORTS, default 2: number of combinational read ports.
REQ-002 SHALL provide parameter WRITE_PORTS, default 2: number of result-broadcast write ports.
REQ-003 SHALL provide parameter RS_ID_WIDTH, default 5: reservation-station tag width.
REQ-004 SHALL provide parameter NUM_SPR, default 3: number of implemented SPRs.
REQ-005 SHALL provide parameter SPR_ADDRS, array of NUM_SPR 10-bit values, default {1, 8, 9} (XER, LR, CTR): the SPR address of each entry.
REQ-006 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have ports read_addr[READ_PORTS], input, 10: read address.
REQ-009 SHALL have ports read_value_valid / read_value / read_rs_id [READ_PORTS], output, 1/32/RS_ID_WIDTH: entry state.
REQ-010 SHALL have ports read_illegal[READ_PORTS], output, 1: read_addr matches no SPR_ADDRS entry.
REQ-011 SHALL have ports write_enable / write_addr / write_rs_id / write_value [WRITE_PORTS], input, 1/10/RS_ID_WIDTH/32: result broadcast.
REQ-012 SHALL have ports update_enable / update_addr / update_rs_id, input, 1/10/RS_ID_WIDTH: rename (invalidate and assign tag).
REQ-013 SHALL have port flush, input, 1: discard all outstanding renames.
REQ-014 SHALL have ports err_valid / err_addr / err_src, output, 1/10/2: sticky illegal-access record (err_src: 0 read, 1 write, 2 update).
REQ-015 SHALL have port err_clear, input, 1: clears the error record.

Function
REQ-016 Each entry SHALL hold value_valid, value[32] and rs_id[RS_ID_WIDTH].
REQ-017 A read SHALL be combinational: mapped entries return the stored state; unmapped addresses return valid=0, value=0, rs_id=0, read_illegal=1.
REQ-018 A write port SHALL commit its value only if the entry is invalid, write_rs_id equals the stored rs_id and the write is enabled; the entry then becomes valid. Tag-mismatched or already-valid writes SHALL be ignored without error.
REQ-019 Rename SHALL take effect one cycle after update_enable: entry valid=0, rs_id=update_rs_id, value unchanged.
REQ-020 Same cycle, same entry, update and matching write SHALL resolve as update wins: valid=0, new tag; the written value SHALL still be stored.
REQ-021 If several write ports match the same entry in one cycle, the lowest-index port SHALL win.
REQ-022 Read bypass: if a read hits an invalid entry and a write port matches that entry's tag in the same cycle, the read SHALL return valid=1 with that port's write_value (REQ-021 priority applies).
REQ-023 A same-cycle update SHALL NOT be visible to reads until the next cycle.
REQ-024 flush SHALL set every entry valid on the next edge, keeping values. Flush SHALL have priority over update and writes in the same cycle.
REQ-025 An enabled write or update to an unmapped address SHALL change no entry. A read is treated as illegal only when read_illegal=1.
REQ-026 The first illegal access while err_valid=0 SHALL set err_valid=1 and capture err_addr and err_src. Priority within a cycle: update, then lowest write port, then lowest read port. Later errors SHALL NOT overwrite the record.
REQ-027 err_clear SHALL clear err_valid next cycle. If a new illegal access arrives in the same cycle, it SHALL be captured instead.
REQ-028 Address decode SHALL be an exact 10-bit compare against SPR_ADDRS. Duplicate SPR_ADDRS entries are a configuration error, with the lowest index used.

Reset
REQ-029 While rst=0, every entry SHALL be valid=1, value=0, rs_id=0, and err_valid=0, err_addr=0, err_src=0, asynchronously.
REQ-030 Deassertion of rst SHALL be synchronised externally. The first active edge after release SHALL behave normally.
REQ-031 Reset asserted mid-operation SHALL discard all pending renames and errors immediately.

Verification
REQ-032 Sequence: update LR (addr 8) tag 3; next cycle write port0 addr 8 tag 3 value 0xDEADBEEF -> read LR valid=0 rs_id=3; during the write cycle bypass gives valid=1 0xDEADBEEF; next cycle stored valid=1.
REQ-033 Stale tag: LR renamed tag 3, then tag 7; write tag 3 value 0x1 -> ignored, LR stays valid=0 rs_id=7; write tag 7 value 0x2 -> valid=1 value 0x2.
REQ-034 Collision: CTR (9) invalid tag 4; same cycle update CTR tag 5 and write tag 4 value 0x55 -> CTR valid=0 rs_id=5 value 0x55.
REQ-035 Dual write: XER invalid tag 2; ports 0 and 1 both tag 2, values 0xA and 0xB -> XER=0xA valid.
REQ-036 Illegal access: read addr 0x3FF -> read_illegal=1, err_valid=1, err_addr=0x3FF, err_src=0; later update addr 2 -> record unchanged; err_clear -> err_valid=0.
REQ-037 Flush/reset: rename all three SPRs, assert flush -> all valid with prior values; rename again, drop rst mid-cycle -> outputs immediately valid=1, value 0, err_valid=0.
